// File: rtl/regfile_mp_if.sv
// Register file access bundle: write ports, read ports, clear control.
// master drives requests, slave is the register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic                    clr_req;
  logic                    busy;
  logic                    we0;
  logic [ADDR_W-1:0]       waddr0;
  logic [DATA_W-1:0]       wdata0;
  logic                    we1;
  logic [ADDR_W-1:0]       waddr1;
  logic [DATA_W-1:0]       wdata1;
  logic [NRD-1:0]          re;
  logic [NRD*ADDR_W-1:0]   raddr;
  logic [NRD*DATA_W-1:0]   rdata;

  modport master (
    output clr_req,
    output we0, waddr0, wdata0,
    output we1, waddr1, wdata1,
    output re, raddr,
    input  busy, rdata
  );

  modport slave (
    input  clr_req,
    input  we0, waddr0, wdata0,
    input  we1, waddr1, wdata1,
    input  re, raddr,
    output busy, rdata
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port GPR file: NRD comb reads, 2 writes (port 1 wins),
// write->read forwarding and a sweep-based array clear.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              busy;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_CLEAR;
      ptr   <= '0;
    end else begin
      unique case (state)
        S_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (&ptr) state <= S_IDLE;
        end
        S_IDLE: begin
          if (bus.clr_req) begin
            state <= S_CLEAR;
            ptr   <= '0;
          end
        end
        default: begin
          state <= S_CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign busy     = (state == S_CLEAR);
  assign bus.busy = busy;

  // Array has no reset; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      regs[ptr] <= '0;
    end else begin
      if (bus.we0 && !(ZR && bus.waddr0 == '0))
        regs[bus.waddr0] <= bus.wdata0;
      if (bus.we1 && !(ZR && bus.waddr1 == '0))
        regs[bus.waddr1] <= bus.wdata1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = bus.raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd = '0;
      if (!rst || busy || !bus.re[i])
        rd = '0;
      else if (ZR && ra == '0)
        rd = '0;
      else if (bus.we1 && bus.waddr1 == ra)
        rd = bus.wdata1;
      else if (bus.we0 && bus.waddr0 == ra)
        rd = bus.wdata0;
      else
        rd = regs[ra];
    end

    assign bus.rdata[i*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: ZERO_REG=1 and ZERO_REG=0
// instances driven in lockstep against an array reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 3;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           clr_req;
  logic           we0, we1;
  logic [AW-1:0]  waddr0, waddr1;
  logic [DW-1:0]  wdata0, wdata1;
  logic [NR-1:0]  re;
  logic [NR*AW-1:0] raddr;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] m1 [DEPTH];
  logic [DW-1:0] m0 [DEPTH];
  int rem;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) b1 ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) b0 ();

  assign b1.clr_req = clr_req;
  assign b1.we0     = we0;
  assign b1.waddr0  = waddr0;
  assign b1.wdata0  = wdata0;
  assign b1.we1     = we1;
  assign b1.waddr1  = waddr1;
  assign b1.wdata1  = wdata1;
  assign b1.re      = re;
  assign b1.raddr   = raddr;

  assign b0.clr_req = clr_req;
  assign b0.we0     = we0;
  assign b0.waddr0  = waddr0;
  assign b0.wdata0  = wdata0;
  assign b0.we1     = we1;
  assign b0.waddr1  = waddr1;
  assign b0.wdata1  = wdata1;
  assign b0.re      = re;
  assign b0.raddr   = raddr;

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1)
  ) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(0)
  ) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );

  task automatic chk(string tag, logic [DW-1:0] obs,
                     logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int a = 0; a < DEPTH; a++) begin
      m1[a] = '0;
      m0[a] = '0;
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(bit zr, int i);
    logic [AW-1:0] a;
    a = raddr[i*AW +: AW];
    if (!rst || rem > 0 || !re[i]) return '0;
    if (zr && a == 0) return '0;
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && waddr0 == a) return wdata0;
    return zr ? m1[a] : m0[a];
  endfunction

  task automatic check_reads(string tag);
    #1;
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s_z1_p%0d", tag, i),
          b1.rdata[i*DW +: DW], exp_rd(1'b1, i));
      chk($sformatf("%s_z0_p%0d", tag, i),
          b0.rdata[i*DW +: DW], exp_rd(1'b0, i));
    end
  endtask

  task automatic model_update();
    if (!rst) begin
      rem = DEPTH;
      return;
    end
    if (rem > 0) begin
      rem--;
      return;
    end
    if (we0) begin
      if (waddr0 != 0) m1[waddr0] = wdata0;
      m0[waddr0] = wdata0;
    end
    if (we1) begin
      if (waddr1 != 0) m1[waddr1] = wdata1;
      m0[waddr1] = wdata1;
    end
    if (clr_req) begin
      rem = DEPTH;
      clear_model();
    end
  endtask

  task automatic cycle(string tag);
    check_reads(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk({tag, "_busy1"}, {31'd0, b1.busy}, {31'd0, rem > 0});
    chk({tag, "_busy0"}, {31'd0, b0.busy}, {31'd0, rem > 0});
  endtask

  task automatic idle_in();
    clr_req = 1'b0;
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
  endtask

  task automatic set_raddr(logic [AW-1:0] a);
    for (int i = 0; i < NR; i++) raddr[i*AW +: AW] = a;
  endtask

  task automatic scan_all(string tag);
    re = '1;
    for (int a = 0; a < DEPTH; a++) begin
      set_raddr(AW'(a));
      check_reads(tag);
    end
  endtask

  task automatic wait_idle(string tag);
    int n;
    n = 0;
    while (n < 64) begin
      cycle(tag);
      n++;
      if (b1.busy === 1'b0) break;
    end
    chk({tag, "_len"}, DW'(n), DW'(DEPTH));
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    re = '1;
    raddr = '0;
    rem = DEPTH;
    clear_model();

    // T1: reset and release
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, b1.busy}, 32'd1);
    check_reads("rst_rd");
    rst = 1'b1;
    wait_idle("t1");
    scan_all("t1_scan");

    // T2: write clash on address 5
    we0 = 1'b1; waddr0 = 5; wdata0 = 32'hAAAA_AAAA;
    we1 = 1'b1; waddr1 = 5; wdata1 = 32'h5555_5555;
    set_raddr(5); re = '1;
    #1 chk("t2_fwd", b1.rdata[0 +: DW], 32'h5555_5555);
    cycle("t2");
    idle_in();
    #1 chk("t2_stored", b1.rdata[DW +: DW], 32'h5555_5555);

    // T3: entry 0
    we0 = 1'b1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
    set_raddr(0);
    cycle("t3w");
    idle_in();
    #1;
    chk("t3_z1", b1.rdata[0 +: DW], 32'h0);
    chk("t3_z0", b0.rdata[(NR-1)*DW +: DW], 32'hFFFF_FFFF);

    // T4: forwarding on the last port, then disabled port
    we0 = 1'b1; waddr0 = 7; wdata0 = 32'h1234_5678;
    set_raddr(0);
    raddr[(NR-1)*AW +: AW] = 7;
    #1 chk("t4_fwd", b1.rdata[(NR-1)*DW +: DW], 32'h1234_5678);
    re[NR-1] = 1'b0;
    #1 chk("t4_re0", b1.rdata[(NR-1)*DW +: DW], 32'h0);
    cycle("t4");
    idle_in();
    re = '1;

    // T5: fill, clear request, dropped write during sweep
    for (int a = 1; a < DEPTH; a++) begin
      we0 = 1'b1; waddr0 = AW'(a);
      wdata0 = 32'hA5A5_A5A5 + DW'(a);
      cycle("t5f");
    end
    idle_in();
    scan_all("t5_fill");
    clr_req = 1'b1;
    cycle("t5c");
    clr_req = 1'b0;
    we0 = 1'b1; waddr0 = 3; wdata0 = 32'hDEAD_BEEF;
    wait_idle("t5");
    idle_in();
    scan_all("t5_scan");

    // T6: reset at ptr=10 of a requested sweep
    clr_req = 1'b1;
    cycle("t6c");
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) cycle("t6s");
    rst = 1'b0;
    rem = DEPTH;
    clear_model();
    #1 chk("t6_rst_busy", {31'd0, b1.busy}, 32'd1);
    cycle("t6r");
    rst = 1'b1;
    wait_idle("t6");
    scan_all("t6_scan");

    // Random traffic, occasional clear requests
    for (int k = 0; k < 400; k++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      waddr0 = AW'($urandom_range(0, 7));
      waddr1 = AW'($urandom_range(0, 7));
      wdata0 = $urandom;
      wdata1 = $urandom;
      re = NR'($urandom);
      for (int i = 0; i < NR; i++)
        raddr[i*AW +: AW] = AW'($urandom_range(0, 9));
      clr_req = ($urandom_range(0, 99) == 0);
      cycle("rnd");
    end
    idle_in();
    scan_all("end_scan");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
